cmd_ram_responder: RTL and testbench

Block-RAM-backed responder for the memory command interface (cmdReady/cmdTrigger/cmdAddr/cmdWrite/cmdWriteData/cmdReadData/cmdReadDataValid) normally served by the SDRAM controller. It stands in for the SDRAM controller behind any command initiator, such as the UART command front-end. It adds deterministic init, read-latency and periodic refresh stalls so the initiator's handshake and stall paths get exercised on-board and in simulation without an SDRAM model.

---
 rtl/cmd_ram_responder.sv | 151 +++++++++++++++
 tb/tb_cmd_ram_responder.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_ram_responder.sv
// Block-RAM stand-in for the SDRAM command interface: clears memory after reset,
// answers reads after a fixed latency and inserts periodic refresh stalls.
module cmd_ram_responder #(
  parameter int DepthBits           = 8,
  parameter int ReadLatency         = 3,
  parameter int RefreshPeriodCycles = 64,
  parameter int RefreshBusyCycles   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        cmdReady,
  input  logic        cmdTrigger,
  input  logic [22:0] cmdAddr,
  input  logic        cmdWrite,
  input  logic [15:0] cmdWriteData,
  output logic [15:0] cmdReadData,
  output logic        cmdReadDataValid,
  output logic        didRefresh
);

  localparam int Depth = 1 << DepthBits;
  localparam int ClrW  = DepthBits + 1;
  localparam int LatW  = $clog2(ReadLatency + 1);
  localparam int RefW  = $clog2(RefreshPeriodCycles);
  localparam int BusyW = $clog2(RefreshBusyCycles + 1);

  localparam logic [ClrW-1:0]  ClrLast  = ClrW'(Depth - 1);
  localparam logic [LatW-1:0]  LatLoad  = LatW'(ReadLatency);
  localparam logic [RefW-1:0]  RefLast  = RefW'(RefreshPeriodCycles - 1);
  localparam logic [BusyW-1:0] BusyLast = BusyW'(RefreshBusyCycles - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_REFRESH
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [ClrW-1:0]      clear_cnt;
  logic [RefW-1:0]      ref_cnt;
  logic                 refresh_pending;
  logic [LatW-1:0]      lat_cnt;
  logic [BusyW-1:0]     busy_cnt;
  logic [DepthBits-1:0] rd_addr;
  logic                 accept;
  logic                 ref_wrap;
  logic                 mem_we;
  logic [DepthBits-1:0] mem_waddr;
  logic [15:0]          mem_wdata;
  logic [15:0]          mem [Depth];

  // Upper address bits alias onto the implemented depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cmdAddr[22:DepthBits];

  assign cmdReady = (state_q == ST_IDLE) && !refresh_pending;
  assign accept   = cmdReady && cmdTrigger;
  assign ref_wrap = (ref_cnt == RefLast);

  // NOTE: every signal driven here gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:    if (clear_cnt == ClrLast) state_d = ST_IDLE;
      ST_IDLE: begin
        if (refresh_pending) state_d = ST_REFRESH;
        else if (cmdTrigger) state_d = cmdWrite ? ST_WRITE : ST_READ;
      end
      ST_WRITE:   state_d = ST_IDLE;
      ST_READ:    if (lat_cnt == LatW'(1)) state_d = ST_IDLE;
      ST_REFRESH: if (busy_cnt == BusyLast) state_d = ST_IDLE;
      default:    state_d = ST_INIT;
    endcase
  end

  // Single write port shared by the clear sweep and accepted writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clear_cnt[DepthBits-1:0];
    mem_wdata = '0;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem_we = 1'b1;
      end else if (accept && cmdWrite) begin
        mem_we    = 1'b1;
        mem_waddr = cmdAddr[DepthBits-1:0];
        mem_wdata = cmdWriteData;
      end
    end
  end

  // NOTE: the array carries no reset so it maps onto block RAM; the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_INIT;
      clear_cnt        <= '0;
      ref_cnt          <= '0;
      refresh_pending  <= 1'b0;
      lat_cnt          <= '0;
      busy_cnt         <= '0;
      rd_addr          <= '0;
      cmdReadData      <= '0;
      cmdReadDataValid <= 1'b0;
      didRefresh       <= 1'b0;
    end else begin
      state_q          <= state_d;
      cmdReadDataValid <= 1'b0;

      if (state_q == ST_INIT) clear_cnt <= clear_cnt + ClrW'(1);

      // Free-running refresh timer, held at zero while memory is being cleared.
      if (state_q == ST_INIT || ref_wrap) ref_cnt <= '0;
      else                                 ref_cnt <= ref_cnt + RefW'(1);

      if (state_q == ST_IDLE && refresh_pending) refresh_pending <= 1'b0;
      if (state_q != ST_INIT && ref_wrap)        refresh_pending <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          busy_cnt <= '0;
          if (accept && !cmdWrite) begin
            rd_addr <= cmdAddr[DepthBits-1:0];
            lat_cnt <= LatLoad;
          end
        end
        ST_READ: begin
          if (lat_cnt == LatW'(1)) begin
            cmdReadData      <= mem[rd_addr];
            cmdReadDataValid <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - LatW'(1);
          end
        end
        ST_REFRESH: begin
          if (busy_cnt == BusyLast) didRefresh <= ~didRefresh;
          else                      busy_cnt   <= busy_cnt + BusyW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_ram_responder.sv
// Directed bench for cmd_ram_responder: init sweep, read latency, aliasing,
// refresh collisions, deferred refresh and reset during a read.
module tb_cmd_ram_responder;

  localparam int ReadLatency         = 3;
  localparam int RefreshPeriodCycles = 64;
  localparam int RefreshBusyCycles   = 4;
  localparam int InitCycles          = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmdReady;
  logic        cmdTrigger = 1'b0;
  logic [22:0] cmdAddr = '0;
  logic        cmdWrite = 1'b0;
  logic [15:0] cmdWriteData = '0;
  logic [15:0] cmdReadData;
  logic        cmdReadDataValid;
  logic        didRefresh;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int base    = 0;
  int acc_cnt = 0;

  cmd_ram_responder #(
    .DepthBits          (8),
    .ReadLatency        (ReadLatency),
    .RefreshPeriodCycles(RefreshPeriodCycles),
    .RefreshBusyCycles  (RefreshBusyCycles)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmdReady        (cmdReady),
    .cmdTrigger      (cmdTrigger),
    .cmdAddr         (cmdAddr),
    .cmdWrite        (cmdWrite),
    .cmdWriteData    (cmdWriteData),
    .cmdReadData     (cmdReadData),
    .cmdReadDataValid(cmdReadDataValid),
    .didRefresh      (didRefresh)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && cmdTrigger && cmdReady) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required $finish");
    $fatal(1, "watchdog expired");
  end

  // Refresh timer value in the current cycle, counted from the first ready cycle.
  function automatic int phase();
    return (cyc - base) % RefreshPeriodCycles;
  endfunction

  task automatic wait_phase(input int p);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (phase() == p) break;
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!cmdReady && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmdReady !== 1'b1) begin
      errors++;
      $display("FAIL %s: cmdReady=%b after %0d cycles, required 1", name, cmdReady, n);
    end
  endtask

  task automatic do_write(input logic [22:0] addr, input logic [15:0] data);
    wait_ready("write_ready");
    cmdTrigger   = 1'b1;
    cmdWrite     = 1'b1;
    cmdAddr      = addr;
    cmdWriteData = data;
    @(negedge clk);
    cmdTrigger   = 1'b0;
    cmdWrite     = 1'b0;
    cmdAddr      = 23'h7fffff;
    cmdWriteData = 16'hdead;
  endtask

  // Returns at the falling edge of the valid cycle; lat counts edges after acceptance.
  task automatic do_read(input logic [22:0] addr, output logic [15:0] data, output int lat);
    wait_ready("read_ready");
    cmdTrigger = 1'b1;
    cmdWrite   = 1'b0;
    cmdAddr    = addr;
    @(negedge clk);
    cmdTrigger = 1'b0;
    cmdAddr    = 23'h7fffff;
    lat = 0;
    while (!cmdReadDataValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    data = cmdReadData;
  endtask

  task automatic test_reset_init();
    logic [15:0] d;
    int lat, n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmdReady, cmdReadDataValid, didRefresh} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: ready/valid/refresh=%b, required 000",
               {cmdReady, cmdReadDataValid, didRefresh});
    end
    checks++;
    if (cmdReadData !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0000", cmdReadData);
    end
    rst = 1'b0;
    n = 0;
    while (!cmdReady && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== InitCycles) begin
      errors++;
      $display("FAIL init_length: ready after %0d cycles, required %0d", n, InitCycles);
    end
    base = cyc;
    do_read(23'h000042, d, lat);
    checks++;
    if (d !== 16'h0000) begin
      errors++;
      $display("FAIL init_read_data: got %h, required 0000", d);
    end
    checks++;
    if (lat !== ReadLatency) begin
      errors++;
      $display("FAIL init_read_latency: got %0d, required %0d", lat, ReadLatency);
    end
    checks++;
    if (cmdReady !== 1'b1) begin
      errors++;
      $display("FAIL ready_in_valid_cycle: got %b, required 1", cmdReady);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] d;
    int lat, pulses;
    wait_phase(10);
    do_write(23'h00001a, 16'hbeef);
    checks++;
    if (cmdReady !== 1'b0) begin
      errors++;
      $display("FAIL write_busy: ready=%b, required 0", cmdReady);
    end
    @(negedge clk);
    checks++;
    if (cmdReady !== 1'b1) begin
      errors++;
      $display("FAIL write_spacing: ready=%b two cycles after write, required 1", cmdReady);
    end
    do_read(23'h00001a, d, lat);
    checks++;
    if (d !== 16'hbeef) begin
      errors++;
      $display("FAIL rd_after_wr: got %h, required beef", d);
    end
    checks++;
    if (lat !== ReadLatency) begin
      errors++;
      $display("FAIL rd_latency: got %0d, required %0d", lat, ReadLatency);
    end
    @(negedge clk);
    checks++;
    if (cmdReadDataValid !== 1'b0) begin
      errors++;
      $display("FAIL valid_width: valid=%b one cycle later, required 0", cmdReadDataValid);
    end
    pulses = 0;
    repeat (19) begin
      @(negedge clk);
      if (cmdReadDataValid) pulses++;
    end
    checks++;
    if (pulses !== 0 || cmdReadData !== 16'hbeef) begin
      errors++;
      $display("FAIL data_hold: pulses=%0d data=%h, required 0 and beef", pulses, cmdReadData);
    end
  endtask

  task automatic test_alias();
    logic [15:0] d;
    int lat;
    wait_phase(10);
    do_write(23'h000105, 16'h1234);
    do_write(23'h000077, 16'h5a5a);
    do_read(23'h000005, d, lat);
    checks++;
    if (d !== 16'h1234) begin
      errors++;
      $display("FAIL alias_low: got %h, required 1234", d);
    end
    do_read(23'h000077, d, lat);
    checks++;
    if (d !== 16'h5a5a) begin
      errors++;
      $display("FAIL back_to_back_write: got %h, required 5a5a", d);
    end
    do_read(23'h40001a, d, lat);
    checks++;
    if (d !== 16'hbeef) begin
      errors++;
      $display("FAIL alias_high: got %h, required beef", d);
    end
  endtask

  task automatic test_refresh_collision();
    logic [15:0] d;
    logic old_dr, early;
    int low, acc0, lat;
    wait_phase(0);
    checks++;
    if (cmdReady !== 1'b0) begin
      errors++;
      $display("FAIL refresh_pending_ready: ready=%b, required 0", cmdReady);
    end
    old_dr       = didRefresh;
    acc0         = acc_cnt;
    early        = 1'b0;
    cmdTrigger   = 1'b1;
    cmdWrite     = 1'b1;
    cmdAddr      = 23'h000033;
    cmdWriteData = 16'hc0de;
    low = 0;
    while (!cmdReady && low < 20) begin
      if (didRefresh !== old_dr) early = 1'b1;
      @(negedge clk);
      low++;
    end
    // One IDLE cycle with the refresh pending, then the busy window.
    checks++;
    if (low !== RefreshBusyCycles + 1) begin
      errors++;
      $display("FAIL refresh_stall: ready low %0d cycles, required %0d", low, RefreshBusyCycles + 1);
    end
    checks++;
    if (didRefresh !== ~old_dr || early) begin
      errors++;
      $display("FAIL refresh_toggle: didRefresh=%b early=%b, required %b and 0", didRefresh, early, ~old_dr);
    end
    @(negedge clk);
    checks++;
    if (cmdReady !== 1'b0) begin
      errors++;
      $display("FAIL collision_busy: ready=%b after acceptance, required 0", cmdReady);
    end
    @(negedge clk);
    cmdTrigger = 1'b0;
    cmdWrite   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (acc_cnt - acc0 !== 1) begin
      errors++;
      $display("FAIL single_accept: %0d acceptances, required 1", acc_cnt - acc0);
    end
    do_read(23'h000033, d, lat);
    checks++;
    if (d !== 16'hc0de) begin
      errors++;
      $display("FAIL collision_data: got %h, required c0de", d);
    end
  endtask

  task automatic test_deferred_refresh();
    logic [15:0] d;
    logic old_dr;
    int lat, n;
    wait_phase(62);
    old_dr = didRefresh;
    do_read(23'h00001a, d, lat);
    checks++;
    if (d !== 16'hbeef || lat !== ReadLatency) begin
      errors++;
      $display("FAIL deferred_read: data=%h lat=%0d, required beef and %0d", d, lat, ReadLatency);
    end
    checks++;
    if (cmdReady !== 1'b0) begin
      errors++;
      $display("FAIL deferred_pending: ready=%b in valid cycle, required 0", cmdReady);
    end
    n = 0;
    while (!cmdReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== RefreshBusyCycles + 1 || didRefresh !== ~old_dr) begin
      errors++;
      $display("FAIL deferred_refresh: ready after %0d didRefresh=%b, required %0d and %b",
               n, didRefresh, RefreshBusyCycles + 1, ~old_dr);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] d;
    int lat, n, pulses;
    wait_phase(20);
    wait_ready("midread_ready");
    cmdTrigger = 1'b1;
    cmdWrite   = 1'b0;
    cmdAddr    = 23'h00001a;
    @(negedge clk);
    cmdTrigger = 1'b0;
    rst        = 1'b1;
    pulses     = 0;
    repeat (3) begin
      @(negedge clk);
      if (cmdReadDataValid) pulses++;
    end
    checks++;
    if ({cmdReady, cmdReadDataValid, didRefresh} !== 3'b000 || cmdReadData !== 16'h0000) begin
      errors++;
      $display("FAIL midread_reset_values: flags=%b data=%h, required 000 and 0000",
               {cmdReady, cmdReadDataValid, didRefresh}, cmdReadData);
    end
    rst = 1'b0;
    n = 0;
    while (!cmdReady && n < 1000) begin
      @(negedge clk);
      n++;
      if (cmdReadDataValid) pulses++;
    end
    checks++;
    if (pulses !== 0 || n !== InitCycles) begin
      errors++;
      $display("FAIL midread_drop: pulses=%0d init=%0d, required 0 and %0d", pulses, n, InitCycles);
    end
    base = cyc;
    do_read(23'h00001a, d, lat);
    checks++;
    if (d !== 16'h0000 || lat !== ReadLatency) begin
      errors++;
      $display("FAIL recleared: data=%h lat=%0d, required 0000 and %0d", d, lat, ReadLatency);
    end
  endtask

  initial begin
    test_reset_init();
    test_write_read();
    test_alias();
    test_refresh_collision();
    test_deferred_refresh();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
